// File: rtl/loop_nest_seq.sv
// loop_nest_seq: three-deep loop-nest index generator.
// IDX_X is the innermost loop and IDX_Z the outermost. One tuple is offered
// per RUN cycle under a valid/ready handshake. A pass ends with a one-cycle
// DONE pulse in FIN, after which the block returns to IDLE.
module loop_nest_seq #(
    parameter int IDX_W = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [IDX_W-1:0]     CFG_MAX_X,
    input  logic [IDX_W-1:0]     CFG_MAX_Y,
    input  logic [IDX_W-1:0]     CFG_MAX_Z,
    input  logic                 OUT_READY,
    output logic                 OUT_VALID,
    output logic [IDX_W-1:0]     IDX_X,
    output logic [IDX_W-1:0]     IDX_Y,
    output logic [IDX_W-1:0]     IDX_Z,
    output logic                 LAST,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [3*IDX_W:0]     XFER_CNT
);

    // The largest pass is (2^IDX_W)^3 = 2^(3*IDX_W) tuples. That count needs
    // one bit more than 3*IDX_W, so the count can never wrap.
    localparam int CNT_W = 3*IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_x_q, idx_x_d;
    logic [IDX_W-1:0]   idx_y_q, idx_y_d;
    logic [IDX_W-1:0]   idx_z_q, idx_z_d;
    logic [IDX_W-1:0]   max_x_q, max_x_d;
    logic [IDX_W-1:0]   max_y_q, max_y_d;
    logic [IDX_W-1:0]   max_z_q, max_z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_s;
    logic               last_s;
    logic               xfer_s;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Decode the handshake and the final-tuple condition from the current state.
    always_comb begin
        run_s  = (state_q == ST_RUN);
        xfer_s = run_s && OUT_READY;
        last_s = run_s && (idx_x_q == max_x_q) && (idx_y_q == max_y_q)
                       && (idx_z_q == max_z_q);
    end

    // Compute the next state, indices, latched bounds and transfer count.
    always_comb begin
        state_d = state_q;
        idx_x_d = idx_x_q;
        idx_y_d = idx_y_q;
        idx_z_d = idx_z_q;
        max_x_d = max_x_q;
        max_y_d = max_y_q;
        max_z_d = max_z_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RUN;
                    max_x_d = CFG_MAX_X;
                    max_y_d = CFG_MAX_Y;
                    max_z_d = CFG_MAX_Z;
                    idx_x_d = {IDX_W{1'b0}};
                    idx_y_d = {IDX_W{1'b0}};
                    idx_z_d = {IDX_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_s) begin
                        // The indices stay at their maxima after the final tuple.
                        state_d = ST_FIN;
                    end else if (idx_x_q != max_x_q) begin
                        idx_x_d = idx_x_q + IDX_ONE;
                    end else if (idx_y_q != max_y_q) begin
                        idx_x_d = {IDX_W{1'b0}};
                        idx_y_d = idx_y_q + IDX_ONE;
                    end else begin
                        idx_x_d = {IDX_W{1'b0}};
                        idx_y_d = {IDX_W{1'b0}};
                        idx_z_d = idx_z_q + IDX_ONE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // ABORT overrides START and any transfer. The count is left alone.
        if (ABORT) begin
            state_d = ST_IDLE;
            idx_x_d = {IDX_W{1'b0}};
            idx_y_d = {IDX_W{1'b0}};
            idx_z_d = {IDX_W{1'b0}};
            cnt_d   = cnt_q;
        end else begin
            cnt_d   = cnt_d;
        end
    end

    // State registers, all cleared asynchronously by RESET_N.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            idx_x_q <= {IDX_W{1'b0}};
            idx_y_q <= {IDX_W{1'b0}};
            idx_z_q <= {IDX_W{1'b0}};
            max_x_q <= {IDX_W{1'b0}};
            max_y_q <= {IDX_W{1'b0}};
            max_z_q <= {IDX_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_x_q <= idx_x_d;
            idx_y_q <= idx_y_d;
            idx_z_q <= idx_z_d;
            max_x_q <= max_x_d;
            max_y_q <= max_y_d;
            max_z_q <= max_z_d;
            cnt_q   <= cnt_d;
        end
    end

    assign OUT_VALID = run_s;
    assign LAST      = last_s;
    assign BUSY      = (state_q == ST_RUN) || (state_q == ST_FIN);
    assign DONE      = (state_q == ST_FIN);
    assign IDX_X     = idx_x_q;
    assign IDX_Y     = idx_y_q;
    assign IDX_Z     = idx_z_q;
    assign XFER_CNT  = cnt_q;

endmodule

// File: tb/tb_loop_nest_seq.sv
// tb_loop_nest_seq: directed test of loop_nest_seq.
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
module tb_loop_nest_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort_s = 1'b0;
    logic [3:0]  cfg_x = 4'd0;
    logic [3:0]  cfg_y = 4'd0;
    logic [3:0]  cfg_z = 4'd0;
    logic        rdy = 1'b0;
    logic        out_valid;
    logic [3:0]  idx_x, idx_y, idx_z;
    logic        last_o, busy, done;
    logic [12:0] xfer_cnt;

    int checks = 0;
    int failures = 0;

    loop_nest_seq #(.IDX_W(4)) dut (
        .CLK(clk), .RESET_N(rst_n), .START(start), .ABORT(abort_s),
        .CFG_MAX_X(cfg_x), .CFG_MAX_Y(cfg_y), .CFG_MAX_Z(cfg_z),
        .OUT_READY(rdy), .OUT_VALID(out_valid),
        .IDX_X(idx_x), .IDX_Y(idx_y), .IDX_Z(idx_z),
        .LAST(last_o), .BUSY(busy), .DONE(done), .XFER_CNT(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_x"}, 32'(idx_x), 32'd0);
        check({tag, "_y"}, 32'(idx_y), 32'd0);
        check({tag, "_z"}, 32'(idx_z), 32'd0);
        check({tag, "_last"}, 32'(last_o), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cnt"}, 32'(xfer_cnt), 32'd0);
    endtask

    // One full pass. The expected tuple order comes from plain nested loops.
    // With rnd set, OUT_READY toggles randomly, and the indices are checked on
    // every stalled cycle. With disturb set, START is held and CFG_MAX_X is
    // changed once RUN is entered; both must be ignored.
    task automatic run_pass(input int mx, input int my, input int mz,
                            input bit rnd, input bit disturb, input string tag);
        int n;
        int dones;
        int stall;
        int prod;
        bit r;
        prod = (mx + 1) * (my + 1) * (mz + 1);
        cfg_x = 4'(mx); cfg_y = 4'(my); cfg_z = 4'(mz);
        start = 1'b1; rdy = 1'b0;
        tick();
        start = 1'b0;
        if (disturb) begin
            start = 1'b1;
            cfg_x = 4'(mx) ^ 4'hF;
            cfg_y = 4'(my) ^ 4'h3;
        end
        n = 0;
        dones = 0;
        for (int z = 0; z <= mz; z++) begin
            for (int y = 0; y <= my; y++) begin
                for (int x = 0; x <= mx; x++) begin
                    stall = 0;
                    do begin
                        r = rnd ? (($urandom_range(0, 1) == 1) || (stall >= 4)) : 1'b1;
                        rdy = r;
                        check({tag, "_valid"}, 32'(out_valid), 32'd1);
                        check({tag, "_x"}, 32'(idx_x), 32'(x));
                        check({tag, "_y"}, 32'(idx_y), 32'(y));
                        check({tag, "_z"}, 32'(idx_z), 32'(z));
                        check({tag, "_last"}, 32'(last_o),
                              32'((x == mx) && (y == my) && (z == mz)));
                        check({tag, "_cnt_run"}, 32'(xfer_cnt), 32'(n));
                        if (done) dones++;
                        tick();
                        stall++;
                    end while (!r);
                    n++;
                end
            end
        end
        start = 1'b0;
        // FIN cycle.
        check({tag, "_fin_done"}, 32'(done), 32'd1);
        check({tag, "_fin_busy"}, 32'(busy), 32'd1);
        check({tag, "_fin_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_fin_x"}, 32'(idx_x), 32'(mx));
        check({tag, "_fin_z"}, 32'(idx_z), 32'(mz));
        check({tag, "_cnt"}, 32'(xfer_cnt), 32'(prod));
        if (done) dones++;
        tick();
        if (done) dones++;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_cnt"}, 32'(xfer_cnt), 32'(prod));
        tick();
        if (done) dones++;
        check({tag, "_dones"}, 32'(dones), 32'd1);
        check({tag, "_idle2_busy"}, 32'(busy), 32'd0);
        rdy = 1'b0;
    endtask

    initial begin
        // Reset state, observed while RESET_N is still low.
        #12;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // MAX=(1,1,0), OUT_READY held high.
        run_pass(1, 1, 0, 1'b0, 1'b0, "p110");
        // MAX=(2,0,1), OUT_READY random.
        run_pass(2, 0, 1, 1'b1, 1'b0, "p201");
        // MAX=(0,0,0): a single tuple that is also LAST.
        run_pass(0, 0, 0, 1'b0, 1'b0, "p000");

        // ABORT together with the transfer of tuple (1,0,0), MAX=(3,3,3).
        cfg_x = 4'd3; cfg_y = 4'd3; cfg_z = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        rdy = 1'b1;
        tick();
        check("ab_pre_x", 32'(idx_x), 32'd1);
        check("ab_pre_cnt", 32'(xfer_cnt), 32'd1);
        abort_s = 1'b1;
        start = 1'b1;
        tick();
        abort_s = 1'b0;
        start = 1'b0;
        rdy = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_valid", 32'(out_valid), 32'd0);
        check("ab_x", 32'(idx_x), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        check("ab_cnt", 32'(xfer_cnt), 32'd1);
        tick();
        check("ab_done2", 32'(done), 32'd0);
        check("ab_busy2", 32'(busy), 32'd0);

        // START and CFG changes during RUN are ignored.
        run_pass(1, 2, 0, 1'b0, 1'b1, "pdis");

        // RESET_N pulsed low mid-pass with MAX=(15,15,15).
        cfg_x = 4'd15; cfg_y = 4'd15; cfg_z = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        rdy = 1'b1;
        repeat (5) tick();
        check("rs_pre_x", 32'(idx_x), 32'd5);
        check("rs_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rs_async");
        #3;
        rst_n = 1'b1;
        rdy = 1'b0;
        repeat (3) begin
            tick();
            check("rs_idle_done", 32'(done), 32'd0);
            check("rs_idle_busy", 32'(busy), 32'd0);
        end
        run_pass(1, 0, 1, 1'b1, 1'b0, "prst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
